// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port integer register file.
package regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   // Address width for an n-entry file; never narrower than one bit.
   function automatic int rf_aw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// Read value select for one read port: hardwired zero, then write-first
// forwarding (highest-index write port wins), then the stored value.
module regfile_fwd_sel
   import regfile_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = rf_aw(NREGS)
) (
   input  logic [AW-1:0]          raddr,
   input  logic [XLEN-1:0]        mem_val,
   input  logic [NUM_WR-1:0]      we,
   input  logic [NUM_WR*AW-1:0]   waddr,
   input  logic [NUM_WR*XLEN-1:0] wdata,
   output logic [XLEN-1:0]        rval
);

   always_comb begin
      rval = mem_val;
      // Ascending scan so a later (higher-index) match overrides earlier ones.
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j] && (waddr[j*AW +: AW] == raddr))
            rval = wdata[j*XLEN +: XLEN];
      end
      if ((ZERO_REG != 0) && (raddr == '0))
         rval = '0;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, same-cycle forwarding and a
// sequenced clear after reset; ready is high once every entry has been zeroed.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = rf_aw(NREGS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_RD-1:0]      ren,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   input  logic [NUM_WR-1:0]      we,
   input  logic [NUM_WR*AW-1:0]   waddr,
   input  logic [NUM_WR*XLEN-1:0] wdata,
   output logic                   ready
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   rf_state_t              state, state_nxt;
   logic [AW-1:0]          clr_idx;
   logic [XLEN-1:0]        mem [NREGS];
   logic [NUM_WR-1:0]      wfwd;
   logic [NUM_WR-1:0]      wkeep;
   logic [NUM_RD*XLEN-1:0] rsel;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= (state == RF_CLEAR) ? clr_idx + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      if ((state == RF_CLEAR) && (clr_idx == LAST_IDX))
         state_nxt = RF_RUN;
   end

   always_comb begin
      ready = (state == RF_RUN);
   end

   // A write port commits only in RUN, outside reset, not to a hardwired x0,
   // and only if no higher-index port targets the same address this cycle.
   always_comb begin
      wfwd  = '0;
      wkeep = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         wfwd[j]  = we[j] && (state == RF_RUN);
         wkeep[j] = wfwd[j] && !reset &&
                    !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0));
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*AW +: AW] == waddr[j*AW +: AW]))
               wkeep[j] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == RF_CLEAR) begin
            mem[clr_idx] <= '0;
         end else begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wkeep[j])
                  mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_fwd_sel #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_sel (
         .raddr   (raddr[i*AW +: AW]),
         .mem_val (mem[raddr[i*AW +: AW]]),
         .we      (wfwd),
         .waddr   (waddr),
         .wdata   (wdata),
         .rval    (rsel[i*XLEN +: XLEN])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (state == RF_RUN) begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (ren[i])
               rdata[i*XLEN +: XLEN] <= rsel[i*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-based reference model,
// plus a second ZERO_REG=0 instance for the ordinary-x0 case.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  ren = '0;
   logic [9:0]  raddr = '0;
   logic [63:0] rdata;
   logic [1:0]  we = '0;
   logic [9:0]  waddr = '0;
   logic [63:0] wdata = '0;
   logic        ready;

   logic        z_ren = 1'b0;
   logic [4:0]  z_raddr = '0;
   logic [31:0] z_rdata;
   logic        z_we = 1'b0;
   logic [4:0]  z_waddr = '0;
   logic [31:0] z_wdata = '0;
   logic        z_ready;

   int tests = 0;
   int fails = 0;

   logic [31:0] model [32];
   logic [31:0] exp_q [2];

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .ren(ren), .raddr(raddr), .rdata(rdata),
      .we(we), .waddr(waddr), .wdata(wdata), .ready(ready)
   );

   regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dut_z (
      .clk(clk), .reset(reset), .ren(z_ren), .raddr(z_raddr), .rdata(z_rdata),
      .we(z_we), .waddr(z_waddr), .wdata(z_wdata), .ready(z_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) model[k] = '0;
      exp_q[0] = '0;
      exp_q[1] = '0;
   endtask

   // One RUN cycle: predict read results from the model, then apply writes.
   task automatic step(input string tag, input logic [1:0] r_en,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] w_en, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
      logic [4:0]  ra [2];
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      ra[0] = ra0; ra[1] = ra1;
      wa[0] = wa0; wa[1] = wa1;
      wd[0] = wd0; wd[1] = wd1;
      ren = r_en; raddr = {ra1, ra0};
      we = w_en;  waddr = {wa1, wa0}; wdata = {wd1, wd0};
      for (int i = 0; i < 2; i++) begin
         if (r_en[i]) begin
            if (ra[i] == 5'd0)                        exp_q[i] = '0;
            else if (w_en[1] && (wa[1] == ra[i]))     exp_q[i] = wd[1];
            else if (w_en[0] && (wa[0] == ra[i]))     exp_q[i] = wd[0];
            else                                      exp_q[i] = model[ra[i]];
         end
      end
      for (int j = 0; j < 2; j++)
         if (w_en[j] && (wa[j] != 5'd0)) model[wa[j]] = wd[j];
      @(posedge clk); #1;
      chk({tag, " rd0"}, rdata[31:0], exp_q[0]);
      chk({tag, " rd1"}, rdata[63:32], exp_q[1]);
   endtask

   // Count cycles until ready while hammering ren/we; rdata must stay 0.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 100) begin
         ren = 2'($urandom); we = 2'($urandom);
         raddr = 10'($urandom); waddr = 10'($urandom);
         wdata = {$urandom, $urandom};
         @(posedge clk); #1;
         n++;
         if (rdata != '0) chk({tag, " clear rdata"}, rdata[31:0] | rdata[63:32], 32'd0);
      end
      ren = '0; we = '0;
      chk({tag, " ready cycles"}, 32'(n), 32'd32);
      chk({tag, " ready"}, {31'd0, ready}, 32'd1);
      chk({tag, " rdata after clear"}, rdata[31:0] | rdata[63:32], 32'd0);
   endtask

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", {31'd0, ready}, 32'd0);
      chk("reset rdata", rdata[31:0] | rdata[63:32], 32'd0);
      reset = 1'b0;
      wait_ready("init");
      chk("z ready", {31'd0, z_ready}, 32'd1);

      for (int a = 0; a < 32; a += 2)
         step("scan", 2'b11, 5'(a), 5'(a + 1), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);

      step("wr x5",   2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
      step("rd x5",   2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("x5 value", rdata[31:0], 32'hDEADBEEF);
      step("fwd x7",  2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 32'h12345678, 32'd0);
      chk("fwd x7 value", rdata[63:32], 32'h12345678);
      step("rb x7",   2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      step("x0 wr",   2'b01, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0);
      step("x0 rb",   2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      step("x9 dual", 2'b01, 5'd9, 5'd0, 2'b11, 5'd9, 5'd9, 32'h1111, 32'h2222);
      chk("x9 fwd value", rdata[31:0], 32'h2222);
      step("x9 rb",   2'b10, 5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("x9 stored", rdata[63:32], 32'h2222);
      step("ld x5",   2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      step("hold a",  2'b00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      step("hold b",  2'b00, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("hold x5", rdata[31:0], 32'hDEADBEEF);

      for (int c = 0; c < 400; c++)
         step("rand", 2'($urandom), rnd_addr(), rnd_addr(), 2'($urandom),
              rnd_addr(), rnd_addr(), $urandom, $urandom);

      // ZERO_REG=0 instance: x0 behaves as an ordinary register.
      z_we = 1'b1; z_waddr = 5'd0; z_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      z_we = 1'b0; z_ren = 1'b1; z_raddr = 5'd0;
      @(posedge clk); #1;
      z_ren = 1'b0;
      chk("z x0 rb", z_rdata, 32'hFFFFFFFF);

      // Reset pulse in RUN with a write in flight to x5; the write is dropped.
      ren = 2'b11; we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hBAD0BAD0};
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      chk("rst pulse ready", {31'd0, ready}, 32'd0);
      wait_ready("rerun");
      step("x5 after rst", 2'b11, 5'd5, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("x5 zero", rdata[31:0], 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the Instruction Decode stage. It is the successor to the single-write, dual-read file and adds:
- configurable read and write port counts;
- same-cycle write-to-read forwarding;
- write-conflict priority;
- per-port read enables;
- a sequenced clear of every entry after reset.

Read data is registered, with one cycle of latency. Decode issue logic must wait for `ready` before using read data.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, 2..64
NUM_RD, 2, number of read ports, 1..4
NUM_WR, 1, number of write ports, 1..2
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high; clock clk
ren  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*AW  packed read addresses; port i is at [i*AW +: AW]; AW = clog2(NREGS)
rdata  out  NUM_RD*XLEN  packed registered read data; port i is at [i*XLEN +: XLEN]
we  in  NUM_WR  per-port write enable
waddr  in  NUM_WR*AW  packed write addresses
wdata  in  NUM_WR*XLEN  packed write data
ready  out  1  1 once clearing is complete and the file is operational

Behaviour:
- State machine, two states: CLEAR and RUN.
- Reset:
  - state <= CLEAR, clr_idx <= 0, all rdata <= 0, ready <= 0.
  - Holding reset high keeps clr_idx at 0.
- CLEAR:
  - Each cycle: mem[clr_idx] <= 0, clr_idx <= clr_idx+1.
  - When clr_idx == NREGS-1, the same cycle writes the last entry and state <= RUN.
  - ready rises exactly NREGS cycles after the first cycle with reset low.
  - we and ren are ignored; rdata holds 0.
- RUN: ready = 1.
- RUN writes:
  - Write port j commits at posedge when we[j]=1, unless ZERO_REG=1 and waddr[j]=0.
  - If two ports target the same address in one cycle, the higher-index port wins and the lower write is dropped.
- RUN reads:
  - If ren[i]=1, rdata[i] <= value(raddr[i]) at posedge, giving 1-cycle latency.
  - If ren[i]=0, rdata[i] holds its previous value.
- Value selection for a read, highest priority first:
  1. ZERO_REG=1 and raddr=0: the value is 0.
  2. Any enabled write port in the same cycle matches raddr: the value is wdata of the highest-index matching port (write-first forwarding).
  3. Otherwise: mem[raddr].
- Forwarding never applies to an address-0 write when ZERO_REG=1.
- Reset asserted in RUN returns to CLEAR and restarts from index 0. An in-flight write in that cycle is dropped.
- Reset asserted mid-CLEAR restarts the clear.
- Memory contents are never undefined after ready=1.
- Reads are registered from an explicit mux, so the array may infer distributed RAM. Block RAM is not required.
- Forwarding compare is an AW-bit equality per (read, write) pair: NUM_RD*NUM_WR comparators.

Decomposition:
- Package regfile_pkg holds:
  - state enum { RF_CLEAR, RF_RUN };
  - default XLEN and NREGS localparams;
  - the helper function for AW.
- One sub-module, regfile_fwd_sel:
  - combinational; instantiated once per read port;
  - inputs: raddr, the mem read value, and the packed we/waddr/wdata;
  - output: the selected value, applying ZERO_REG and write-port priority.
- Top level holds: the array, the CLEAR/RUN FSM with clr_idx, write-commit priority logic, and the rdata registers.

Test Plan:
- Reset high 3 cycles, then low; preload is impossible, so read all 32 entries after ready -> ready rises on exactly cycle 32 after release; every rdata = 0; rdata stays 0 during CLEAR even with ren=1.
- After ready, write x5=0xDEADBEEF; next cycle ren[0]=1, raddr[0]=5 -> rdata[0]=0xDEADBEEF one cycle later.
- Same-cycle forwarding: we[0]=1, waddr=7, wdata=0x12345678, with raddr[1]=7 and ren[1]=1 in that cycle -> rdata[1]=0x12345678 next cycle; x7 later reads back 0x12345678.
- ZERO_REG=1: write x0=0xFFFFFFFF while reading x0 in the same cycle -> rdata=0 then and afterwards. ZERO_REG=0 build: x0 reads back 0xFFFFFFFF.
- NUM_WR=2: both ports write x9, port0=0x1111, port1=0x2222, with a concurrent read of x9 -> forwarded value 0x2222; stored value 0x2222.
- ren[0]=0 while raddr[0] changes from 5 to 7 -> rdata[0] holds 0xDEADBEEF. Reset pulse in RUN -> ready=0 for 32 cycles and x5 then reads 0.
